// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer: Gowin_ADC scan controller averaging 2^AVG_LOG2 samples per channel once per PERIOD
module adc_sample_sequencer #(
   parameter int NUM_CHAN   = 2,
   parameter int AVG_LOG2   = 3,
   parameter int SETTLE_CYC = 64,
   parameter int PERIOD     = 50000,
   parameter int TIMEOUT    = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        adc_en,
   output logic        adc_req,
   output logic [2:0]  adc_vsenctl,
   input  logic        adc_rdy,
   input  logic [13:0] adc_value,
   output logic [13:0] result,
   output logic [2:0]  result_chan,
   output logic        result_valid,
   output logic        timeout_err
);
   localparam int AW = 14 + AVG_LOG2;
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = $clog2(PERIOD + 1);
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD - 1);
   localparam logic [CW-1:0] CNT_LAST     = CW'((1 << AVG_LOG2) - 1);
   localparam logic [2:0]    CHAN_LAST    = 3'(NUM_CHAN - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, EMIT, NEXT, HOLD} state_t;

   state_t        state, state_nx;
   logic [SW-1:0] settle_cnt;
   logic [TW-1:0] wait_cnt;
   logic [PW-1:0] period_cnt;
   logic [CW-1:0] sample_cnt;
   logic [AW-1:0] acc, acc_sum;
   logic [2:0]    chan;
   logic          rdy_prev, rdy_edge, take;

   // only a fresh 0->1 after the request is a sample; rdy already high on entry is ignored
   assign rdy_edge     = adc_rdy & ~rdy_prev;
   assign take         = state == WAIT && enable && rdy_edge;
   assign acc_sum      = acc + AW'(adc_value);
   assign adc_en       = state != IDLE;
   assign adc_req      = state == REQ;
   assign adc_vsenctl  = chan;
   assign result_valid = state == EMIT;
   assign timeout_err  = state == WAIT && enable && !rdy_edge && wait_cnt == TIMEOUT_LAST;

   always_comb begin
      state_nx = state;
      if (!enable) state_nx = IDLE;
      else case (state)
         IDLE:    state_nx = SETTLE;
         SETTLE:  state_nx = settle_cnt == SETTLE_LAST ? REQ : SETTLE;
         REQ:     state_nx = WAIT;
         WAIT:    state_nx = rdy_edge ? (sample_cnt == CNT_LAST ? EMIT : REQ)
                                      : (wait_cnt == TIMEOUT_LAST ? NEXT : WAIT);
         EMIT:    state_nx = NEXT;
         NEXT:    state_nx = chan == CHAN_LAST ? HOLD : SETTLE;
         HOLD:    state_nx = period_cnt == PERIOD_LAST ? SETTLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         wait_cnt    <= '0;
         period_cnt  <= '0;
         sample_cnt  <= '0;
         acc         <= '0;
         chan        <= '0;
         rdy_prev    <= 1'b0;
         result      <= '0;
         result_chan <= '0;
      end else begin
         state      <= state_nx;
         rdy_prev   <= adc_rdy;
         settle_cnt <= state == SETTLE ? settle_cnt + SW'(1) : '0;
         wait_cnt   <= state == WAIT ? wait_cnt + TW'(1) : '0;
         // saturating, so a round that overran PERIOD leaves HOLD after one cycle
         period_cnt <= state == IDLE || (state == HOLD && period_cnt == PERIOD_LAST) ? '0
                     : period_cnt == PERIOD_LAST ? period_cnt : period_cnt + PW'(1);
         if (!enable || state == NEXT) begin
            acc        <= '0;
            sample_cnt <= '0;
         end else if (take) begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + CW'(1);
         end
         if (!enable) chan <= '0;
         else if (state == NEXT) chan <= chan == CHAN_LAST ? 3'd0 : chan + 3'd1;
         if (take && sample_cnt == CNT_LAST) begin
            result      <= acc_sum[AW-1:AVG_LOG2];
            result_chan <= chan;
         end
      end
   end
endmodule
